// File: rtl/wireless_cmd_engine.sv
// rtl/wireless_cmd_engine.sv - byte command/response engine: telemetry snapshot replies, config registers, paced tx FIFO
// Define WIRELESS_CHECKSUM_EN to append an XOR checksum byte to every reply.
module wireless_cmd_engine #(
  parameter int                   NUM_CH     = 4,
  parameter int                   CH_W       = 10,
  parameter int                   NUM_CFG    = 2,
  parameter logic [NUM_CFG*8-1:0] CFG_INIT   = {8'd200, 8'd26},
  parameter int                   FIFO_DEPTH = 8,
  parameter int                   TIMEOUT    = 50000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     received,
  input  logic [7:0]               rx_byte,
  input  logic                     recv_error,
  input  logic                     is_transmitting,
  output logic                     transmit,
  output logic [7:0]               tx_byte,
  input  logic [NUM_CH*CH_W-1:0]   ch_data,
  output logic [NUM_CFG*8-1:0]     cfg,
  output logic [NUM_CFG-1:0]       cfg_wr,
  output logic                     overflow
);

  localparam int NB = (CH_W + 7) / 8;
`ifdef WIRELESS_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif
  localparam int MAXLEN = NB + CSUM;
  localparam int LW     = $clog2(MAXLEN + 1);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

  state_t        state;
  logic [3:0]    idx;
  logic [TW-1:0] timer;

  logic [3:0] rx_hi;
  logic [3:0] rx_lo;
  assign rx_hi = rx_byte[7:4];
  assign rx_lo = rx_byte[3:0];

  // Channel and config selected by the low nibble of the command byte
  logic [NB*8-1:0] ch_sel;
  logic [7:0]      cfg_rd;
  always_comb begin
    ch_sel = '0;
    cfg_rd = 8'h00;
    for (int c = 0; c < NUM_CH; c++)
      if (4'(c) == rx_lo) ch_sel[CH_W-1:0] = ch_data[c*CH_W +: CH_W];
    for (int k = 0; k < NUM_CFG; k++)
      if (4'(k) == rx_lo) cfg_rd = cfg[k*8 +: 8];
  end

  logic [7:0]    dec_bytes [MAXLEN];
  logic [LW-1:0] dec_len;
  logic          dec_wait;
`ifdef WIRELESS_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  always_comb begin
    for (int i = 0; i < MAXLEN; i++) dec_bytes[i] = 8'h00;
    dec_len  = LW'(1);
    dec_wait = 1'b0;
    if (state == S_WAIT) begin
      dec_bytes[0] = recv_error ? 8'h00 : 8'h01;
    end else if (!recv_error) begin
      case (rx_hi)
        4'h0: dec_bytes[0] = (rx_lo == 4'h0) ? 8'hA5 : 8'h00;
        4'h1: if (int'(rx_lo) < NUM_CH) begin
          dec_len = LW'(NB);
          for (int i = 0; i < NB; i++) dec_bytes[i] = ch_sel[(NB-1-i)*8 +: 8];
        end
        4'h2: if (int'(rx_lo) < NUM_CFG) begin
          dec_bytes[0] = 8'h01;
          dec_wait     = 1'b1;
        end
        4'h3: if (int'(rx_lo) < NUM_CFG) dec_bytes[0] = cfg_rd;
        default: ;
      endcase
    end
`ifdef WIRELESS_CHECKSUM_EN
    // Unused slots are zero, so XOR over the whole buffer is the reply checksum
    csum = 8'h00;
    for (int i = 0; i < MAXLEN; i++) csum = csum ^ dec_bytes[i];
    dec_bytes[dec_len] = csum;
    dec_len = dec_len + LW'(1);
`endif
  end

  logic [7:0]    rep_bytes [MAXLEN];
  logic [LW-1:0] rep_len;
  logic          rep_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      timer     <= '0;
      cfg       <= CFG_INIT;
      cfg_wr    <= '0;
      rep_valid <= 1'b0;
      rep_len   <= '0;
      for (int i = 0; i < MAXLEN; i++) rep_bytes[i] <= 8'h00;
    end else begin
      cfg_wr    <= '0;
      rep_valid <= received;
      if (received) begin
        rep_len <= dec_len;
        for (int i = 0; i < MAXLEN; i++) rep_bytes[i] <= dec_bytes[i];
      end
      case (state)
        S_IDLE: begin
          if (received && !recv_error && dec_wait) begin
            state <= S_WAIT;
            idx   <= rx_lo;
            timer <= '0;
          end
        end
        S_WAIT: begin
          if (received) begin
            state <= S_IDLE;
            if (!recv_error)
              for (int k = 0; k < NUM_CFG; k++)
                if (4'(k) == idx) begin
                  cfg[k*8 +: 8] <= rx_byte;
                  cfg_wr[k]     <= 1'b1;
                end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] free_slots;
  logic          push_ok;
  logic          pop;

  // Space is judged before this cycle's pop so a reply is never split
  assign free_slots = CW'(FIFO_DEPTH) - count;
  assign push_ok    = rep_valid && (free_slots >= CW'(rep_len));
  assign pop        = (count != '0) && !is_transmitting && !transmit;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      transmit <= 1'b0;
      tx_byte  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      transmit <= pop;
      if (pop) begin
        tx_byte <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      if (push_ok) begin
        for (int i = 0; i < MAXLEN; i++)
          if (i < int'(rep_len)) mem[wr_ptr + AW'(i)] <= rep_bytes[i];
        wr_ptr <= wr_ptr + AW'(rep_len);
      end
      if (rep_valid && !push_ok) overflow <= 1'b1;
      count <= count + (push_ok ? CW'(rep_len) : CW'(0)) - (pop ? CW'(1) : CW'(0));
    end
  end

endmodule

// File: tb/tb_wireless_cmd_engine.sv
// tb/tb_wireless_cmd_engine.sv - randomized and directed bench for wireless_cmd_engine against a queue-level reply model
module tb_wireless_cmd_engine;

  localparam int NUM_CH     = 4;
  localparam int CH_W       = 10;
  localparam int NUM_CFG    = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int TIMEOUT    = 300;
  localparam int NB         = (CH_W + 7) / 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   received;
  logic [7:0]             rx_byte;
  logic                   recv_error;
  logic                   is_transmitting;
  logic                   transmit;
  logic [7:0]             tx_byte;
  logic [NUM_CH*CH_W-1:0] ch_data;
  logic [NUM_CFG*8-1:0]   cfg;
  logic [NUM_CFG-1:0]     cfg_wr;
  logic                   overflow;

  wireless_cmd_engine #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .NUM_CFG(NUM_CFG),
    .CFG_INIT({8'd200, 8'd26}), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .received(received), .rx_byte(rx_byte),
    .recv_error(recv_error), .is_transmitting(is_transmitting),
    .transmit(transmit), .tx_byte(tx_byte), .ch_data(ch_data),
    .cfg(cfg), .cfg_wr(cfg_wr), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reply model: a queue of bytes per reply, a byte queue for the FIFO
  logic [7:0]           m_q[$];
  logic [7:0]           m_pend[$];
  logic [7:0]           rep[$];
  bit                   m_pend_v;
  bit                   m_wait;
  int                   m_idx;
  int                   m_wait_n;
  logic [NUM_CFG*8-1:0] m_cfg;
  logic [NUM_CFG-1:0]   m_cfg_wr;
  bit                   m_transmit;
  logic [7:0]           m_tx_byte;
  bit                   m_overflow;
  bit                   started = 0;

  initial begin
    int hi;
    int lo;
    bit do_pop;
    bit fits;
    logic [63:0] v;
    logic [7:0]  x;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_q.delete(); m_pend.delete(); m_pend_v = 0;
        m_wait = 0; m_idx = 0; m_wait_n = 0;
        m_cfg = {8'd200, 8'd26}; m_cfg_wr = '0;
        m_transmit = 0; m_tx_byte = 8'h00; m_overflow = 0;
      end else begin
        do_pop = (m_q.size() > 0) && !is_transmitting && !m_transmit;
        fits   = m_pend_v && (FIFO_DEPTH - m_q.size() >= m_pend.size());
        if (m_pend_v && !fits) m_overflow = 1;
        if (do_pop) m_tx_byte = m_q.pop_front();
        m_transmit = do_pop;
        if (fits) foreach (m_pend[i]) m_q.push_back(m_pend[i]);
        m_pend.delete(); m_pend_v = 0;
        m_cfg_wr = '0;
        if (received) begin
          rep.delete();
          hi = int'(rx_byte[7:4]);
          lo = int'(rx_byte[3:0]);
          if (m_wait) begin
            m_wait = 0;
            rep.push_back(recv_error ? 8'h00 : 8'h01);
            if (!recv_error) begin
              m_cfg[m_idx*8 +: 8] = rx_byte;
              m_cfg_wr[m_idx] = 1'b1;
            end
          end else if (recv_error) rep.push_back(8'h00);
          else if (rx_byte == 8'h00) rep.push_back(8'hA5);
          else if (hi == 1 && lo < NUM_CH) begin
            v = 64'(ch_data) >> (lo * CH_W);
            v = v & ((64'd1 << CH_W) - 64'd1);
            for (int i = 0; i < NB; i++) rep.push_back(8'((v >> (8 * (NB - 1 - i))) & 64'hFF));
          end else if (hi == 2 && lo < NUM_CFG) begin
            rep.push_back(8'h01);
            m_wait = 1; m_idx = lo; m_wait_n = 0;
          end else if (hi == 3 && lo < NUM_CFG) rep.push_back(m_cfg[lo*8 +: 8]);
          else rep.push_back(8'h00);
`ifdef WIRELESS_CHECKSUM_EN
          x = 8'h00;
          foreach (rep[i]) x = x ^ rep[i];
          rep.push_back(x);
`endif
          m_pend = rep; m_pend_v = 1;
        end else if (m_wait) begin
          m_wait_n++;
          if (m_wait_n == TIMEOUT) m_wait = 0;
        end
      end
      started = 1;
    end
  end

  logic [7:0] tx_log[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (started) begin
      chk("transmit", 64'(transmit), 64'(m_transmit));
      chk("tx_byte", 64'(tx_byte), 64'(m_tx_byte));
      chk("cfg", 64'(cfg), 64'(m_cfg));
      chk("cfg_wr", 64'(cfg_wr), 64'(m_cfg_wr));
      chk("overflow", 64'(overflow), 64'(m_overflow));
      if (transmit === 1'b1) tx_log.push_back(tx_byte);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b, input logic err);
    received = 1'b1; rx_byte = b; recv_error = err;
    tick();
    received = 1'b0; recv_error = 1'b0;
  endtask

  task automatic check_log(input string name);
    chk({name, "_len"}, 64'(tx_log.size()), 64'(exp_q.size()));
    foreach (exp_q[i])
      if (i < tx_log.size()) chk($sformatf("%s_b%0d", name, i), 64'(tx_log[i]), 64'(exp_q[i]));
    tx_log.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [63:0] r64;
    rst = 1'b1; received = 1'b0; rx_byte = 8'h00; recv_error = 1'b0;
    is_transmitting = 1'b0; ch_data = '0;
    repeat (3) tick();
    chk("rst_transmit", 64'(transmit), 64'd0);
    chk("rst_tx_byte", 64'(tx_byte), 64'd0);
    chk("rst_cfg", 64'(cfg), 64'hC81A);
    chk("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    tick();
    tx_log.delete();

    send(8'h00, 1'b0);
    repeat (10) tick();
    exp_q.push_back(8'hA5);
    check_log("ping");

    ch_data[19:10] = 10'h2C7;
    send(8'h11, 1'b0);
    ch_data[19:10] = 10'h3FF;
    repeat (10) tick();
    exp_q.push_back(8'h02); exp_q.push_back(8'hC7);
`ifdef WIRELESS_CHECKSUM_EN
    exp_q.push_back(8'hC5);
`endif
    check_log("chan1");

    send(8'h21, 1'b0);
    repeat (100) tick();
    send(8'h64, 1'b0);
    chk("cfg_wr_pulse", 64'(cfg_wr), 64'h2);
    chk("cfg_hi", 64'(cfg[15:8]), 64'd100);
    tick();
    chk("cfg_wr_clear", 64'(cfg_wr), 64'h0);
    repeat (10) tick();
    exp_q.push_back(8'h01);
`ifdef WIRELESS_CHECKSUM_EN
    exp_q.push_back(8'h01);
`endif
    exp_q.push_back(8'h01);
`ifdef WIRELESS_CHECKSUM_EN
    exp_q.push_back(8'h01);
`endif
    check_log("set_cfg1");

    send(8'h20, 1'b0);
    repeat (TIMEOUT + 10) tick();
    chk("timeout_cfg_lo", 64'(cfg[7:0]), 64'd26);
    send(8'h30, 1'b0);
    repeat (10) tick();
    exp_q.push_back(8'h01);
`ifdef WIRELESS_CHECKSUM_EN
    exp_q.push_back(8'h01);
`endif
    exp_q.push_back(8'h1A);
`ifdef WIRELESS_CHECKSUM_EN
    exp_q.push_back(8'h1A);
`endif
    check_log("timeout");

    send(8'h7F, 1'b0);
    send(8'h00, 1'b1);
    repeat (10) tick();
    exp_q.push_back(8'h00);
`ifdef WIRELESS_CHECKSUM_EN
    exp_q.push_back(8'h00);
`endif
    exp_q.push_back(8'h00);
`ifdef WIRELESS_CHECKSUM_EN
    exp_q.push_back(8'h00);
`endif
    check_log("nak");

`ifndef WIRELESS_CHECKSUM_EN
    is_transmitting = 1'b1;
    repeat (9) send(8'h00, 1'b0);
    tick();
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_held", 64'(tx_log.size()), 64'd0);
    is_transmitting = 1'b0;
    repeat (40) tick();
    repeat (8) exp_q.push_back(8'hA5);
    check_log("full");
`endif

    is_transmitting = 1'b1;
    send(8'h00, 1'b0);
    send(8'h21, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    is_transmitting = 1'b0;
    chk("rst_mid_ovf", 64'(overflow), 64'd0);
    chk("rst_mid_cfg", 64'(cfg), 64'hC81A);
    send(8'h05, 1'b0);
    repeat (10) tick();
    exp_q.push_back(8'h00);
`ifdef WIRELESS_CHECKSUM_EN
    exp_q.push_back(8'h00);
`endif
    check_log("rst_mid");

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 999) == 0);
      received = ($urandom_range(0, 3) == 0);
      recv_error = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 5))
        0: rx_byte = 8'h00;
        1: rx_byte = 8'h10 + 8'($urandom_range(0, 5));
        2: rx_byte = 8'h20 + 8'($urandom_range(0, 3));
        3: rx_byte = 8'h30 + 8'($urandom_range(0, 3));
        default: rx_byte = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 7) == 0) is_transmitting = ~is_transmitting;
      r64 = {$urandom, $urandom};
      ch_data = r64[NUM_CH*CH_W-1:0];
      tick();
    end
    rst = 1'b0; received = 1'b0; recv_error = 1'b0; is_transmitting = 1'b0;
    repeat (50) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
